// File: rtl/png_pixel_formatter.sv
// Downstream formatter for png_decoder: composites RGBA over a fixed background,
// tags raster position and buffers pixels onto a valid/ready output stream.
module png_pixel_formatter #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [7:0]  BG_R       = 8'h00,
   parameter logic [7:0]  BG_G       = 8'h00,
   parameter logic [7:0]  BG_B       = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        newframe,
   input  logic [1:0]  colortype,
   input  logic [13:0] width,
   input  logic [31:0] height,
   input  logic        ivalid,
   input  logic [7:0]  ipixelr,
   input  logic [7:0]  ipixelg,
   input  logic [7:0]  ipixelb,
   input  logic [7:0]  ipixela,
   input  logic        oready,
   output logic        ovalid,
   output logic [7:0]  opixelr,
   output logic [7:0]  opixelg,
   output logic [7:0]  opixelb,
   output logic        osof,
   output logic        oeol,
   output logic        oeof,
   output logic [1:0]  ocolortype,
   output logic        overflow,
   output logic        extra
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   function automatic logic [16:0] blend_sum(input logic [7:0] c, input logic [7:0] a,
                                             input logic [7:0] bg);
      logic [15:0] fg;
      logic [15:0] bk;
      fg = {8'd0, c} * {8'd0, a};
      bk = {8'd0, bg} * {8'd0, 8'd255 - a};
      return {1'b0, fg} + {1'b0, bk} + 17'd128;
   endfunction

   // (s + s>>8) >> 8 is an exact round-to-nearest division by 255 for this range
   function automatic logic [7:0] norm(input logic [16:0] s);
      logic [16:0] t;
      t = s + {8'd0, s[16:8]};
      return 8'(t >> 8);
   endfunction

   logic [13:0] fw, x, cur_w, cur_x;
   logic [31:0] fh, y, cur_h, cur_y;
   logic [1:0]  fct, cur_ct;
   logic        in_frame, take, sof_c, eol_c, eof_c;

   // A pixel coincident with newframe belongs to the new frame.
   always_comb begin
      cur_w    = newframe ? width     : fw;
      cur_h    = newframe ? height    : fh;
      cur_ct   = newframe ? colortype : fct;
      cur_x    = newframe ? '0        : x;
      cur_y    = newframe ? '0        : y;
      in_frame = (cur_w != '0) && (cur_h != '0) && (cur_y < cur_h);
      take     = ivalid && in_frame;
      sof_c    = (cur_x == '0) && (cur_y == '0);
      eol_c    = (cur_x == cur_w - 14'd1);
      eof_c    = eol_c && (cur_y == cur_h - 32'd1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fw    <= '0;
         fh    <= '0;
         fct   <= '0;
         x     <= '0;
         y     <= '0;
         extra <= 1'b0;
      end else begin
         if (newframe) begin
            fw  <= width;
            fh  <= height;
            fct <= colortype;
         end
         if (take) begin
            x <= eol_c ? '0 : cur_x + 14'd1;
            y <= eol_c ? cur_y + 32'd1 : cur_y;
         end else if (newframe) begin
            x <= '0;
            y <= '0;
         end
         extra <= (newframe ? 1'b0 : extra) | (ivalid && !in_frame);
      end
   end

   logic        s1_valid, s1_sof, s1_eol, s1_eof;
   logic [16:0] s1_sr, s1_sg, s1_sb;
   logic [1:0]  s1_ct;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_sr    <= '0;
         s1_sg    <= '0;
         s1_sb    <= '0;
         s1_sof   <= 1'b0;
         s1_eol   <= 1'b0;
         s1_eof   <= 1'b0;
         s1_ct    <= '0;
      end else begin
         s1_valid <= take;
         if (take) begin
            s1_sr  <= blend_sum(ipixelr, ipixela, BG_R);
            s1_sg  <= blend_sum(ipixelg, ipixela, BG_G);
            s1_sb  <= blend_sum(ipixelb, ipixela, BG_B);
            s1_sof <= sof_c;
            s1_eol <= eol_c;
            s1_eof <= eof_c;
            s1_ct  <= cur_ct;
         end
      end
   end

   // FIFO occupancy counts the output register as one of the FIFO_DEPTH entries.
   logic [28:0]   mem [FIFO_DEPTH];
   logic [28:0]   wdata;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] mcount, total;
   logic          pop, accept, load;

   always_comb begin
      wdata  = {norm(s1_sr), norm(s1_sg), norm(s1_sb), s1_sof, s1_eol, s1_eof, s1_ct};
      pop    = ovalid && oready;
      total  = mcount + CW'(ovalid);
      accept = s1_valid && ((total < DEPTH_C) || pop);
      load   = (!ovalid || pop) && (mcount != '0);
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mcount     <= '0;
         ovalid     <= 1'b0;
         opixelr    <= '0;
         opixelg    <= '0;
         opixelb    <= '0;
         osof       <= 1'b0;
         oeol       <= 1'b0;
         oeof       <= 1'b0;
         ocolortype <= '0;
         overflow   <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (load)   rd_ptr <= rd_ptr + AW'(1);
         case ({accept, load})
            2'b10:   mcount <= mcount + CW'(1);
            2'b01:   mcount <= mcount - CW'(1);
            default: mcount <= mcount;
         endcase
         if (load) begin
            ovalid <= 1'b1;
            {opixelr, opixelg, opixelb, osof, oeol, oeof, ocolortype} <= mem[rd_ptr];
         end else if (pop) begin
            ovalid <= 1'b0;
         end
         overflow <= (newframe ? 1'b0 : overflow) | (s1_valid && !accept);
      end
   end

endmodule
